// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants used by the encoder and Main_controller,
// the 3-bit instruction class encoding and an immediate range helper.
package riscv_pkg;

    localparam logic [6:0] R_T  = 7'b0110011;
    localparam logic [6:0] I_T  = 7'b0010011;
    localparam logic [6:0] S_T  = 7'b0100011;
    localparam logic [6:0] B_T  = 7'b1100011;
    localparam logic [6:0] U_T  = 7'b0110111;
    localparam logic [6:0] J_T  = 7'b1101111;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] JALR = 7'b1100111;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_S    = 3'd2,
        CLS_B    = 3'd3,
        CLS_U    = 3'd4,
        CLS_J    = 3'd5,
        CLS_LW   = 3'd6,
        CLS_JALR = 3'd7
    } instr_class_t;

    // True when value is representable as a two's-complement number of the given width.
    function automatic logic fitsSigned(input logic [31:0] value, input int unsigned width);
        logic [31:0] upper;
        upper = $signed(value) >>> (width - 1);
        return (upper == 32'h0) || (upper == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_format_enc.sv
// Combinational RV32I word builder: scatters fields and immediate per class and
// flags whether the immediate fits the target format.
module instr_format_enc
    import riscv_pkg::*;
(
    input  instr_class_t cls_i,
    input  logic [4:0]   rd_i,
    input  logic [4:0]   rs1_i,
    input  logic [4:0]   rs2_i,
    input  logic [2:0]   funct3_i,
    input  logic [6:0]   funct7_i,
    input  logic [31:0]  imm_i,
    output logic [31:0]  word_o,
    output logic         imm_ok_o
);

    always_comb begin
        word_o   = 32'h0;
        imm_ok_o = 1'b1;
        case (cls_i)
            CLS_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, R_T};
            end
            CLS_I: begin
                // Shift immediates take their upper bits from funct7 (slli/srli/srai).
                if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
                    word_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, I_T};
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, I_T};
                end
                imm_ok_o = fitsSigned(imm_i, 12);
            end
            CLS_S: begin
                word_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], S_T};
                imm_ok_o = fitsSigned(imm_i, 12);
            end
            CLS_B: begin
                word_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], B_T};
                imm_ok_o = fitsSigned(imm_i, 13) && !imm_i[0];
            end
            CLS_U: begin
                word_o   = {imm_i[31:12], rd_i, U_T};
                imm_ok_o = (imm_i[11:0] == 12'h0);
            end
            CLS_J: begin
                word_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, J_T};
                imm_ok_o = fitsSigned(imm_i, 21) && !imm_i[0];
            end
            CLS_LW: begin
                word_o   = {imm_i[11:0], rs1_i, 3'b010, rd_i, LW};
                imm_ok_o = fitsSigned(imm_i, 12);
            end
            CLS_JALR: begin
                word_o   = {imm_i[11:0], rs1_i, 3'b000, rd_i, JALR};
                imm_ok_o = fitsSigned(imm_i, 12);
            end
            default: begin
                word_o   = 32'h0;
                imm_ok_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes one instruction per cycle and writes it to instruction memory.
// Define ENCODER_IMM_CHECK_EN to reject out-of-range immediates and raise the sticky error.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    in_class,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [2:0]    in_funct3,
    input  logic [6:0]    in_funct7,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          error
);

    typedef enum logic {
        ST_LOAD,
        ST_DONE
    } enc_state_t;

    enc_state_t    state_q;
    logic [CW-1:0] count_q;
    logic          memWe_q;
    logic [31:0]   memAddr_q;
    logic [31:0]   memWdata_q;
    logic          done_q;
    logic          error_q;

    logic [31:0]   encWord;
    logic          immOk;
    logic          accept;
    logic          legal;
    logic          fills;
    logic [31:0]   memAddr_d;

    instr_format_enc u_format (
        .cls_i    (instr_class_t'(in_class)),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_imm),
        .word_o   (encWord),
        .imm_ok_o (immOk)
    );

`ifdef ENCODER_IMM_CHECK_EN
    assign legal = immOk;
`else
    logic unusedImmOk;
    assign unusedImmOk = immOk;
    assign legal       = 1'b1;
`endif

    assign in_ready  = (state_q == ST_LOAD) && !start;
    assign accept    = in_valid && in_ready;
    assign fills     = (count_q == CW'(DEPTH - 1));
    assign memAddr_d = BASE_ADDR + (32'(count_q) << 2);

    // Leaving LOAD on the accept edge keeps in_ready low before a DEPTH+1th word can slip in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= BASE_ADDR;
            memWdata_q <= 32'h0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            memWe_q <= 1'b0;
            if (start) begin
                state_q <= ST_LOAD;
                count_q <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    memWe_q    <= 1'b1;
                    memAddr_q  <= memAddr_d;
                    memWdata_q <= encWord;
                    count_q    <= count_q + CW'(1);
                end else begin
                    error_q <= 1'b1;
                end
                if (in_last || (legal && fills)) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4, non-zero base) with hand-encoded RV32I words;
// the immediate-rejection vectors follow ENCODER_IMM_CHECK_EN.
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inValid;
    logic        inReady;
    logic        inLast;
    logic [2:0]  inClass;
    logic [4:0]  inRd;
    logic [4:0]  inRs1;
    logic [4:0]  inRs2;
    logic [2:0]  inFunct3;
    logic [6:0]  inFunct7;
    logic [31:0] inImm;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [2:0]  count;
    logic        done;
    logic        error;

    int vecCount  = 0;
    int missCount = 0;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_last   (inLast),
        .in_class  (inClass),
        .in_rd     (inRd),
        .in_rs1    (inRs1),
        .in_rs2    (inRs2),
        .in_funct3 (inFunct3),
        .in_funct7 (inFunct7),
        .in_imm    (inImm),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .count     (count),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one bundle for a single edge and returns #1 into the following cycle.
    task automatic applyStimulus(input logic [2:0] cls, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic last);
        inValid  = 1'b1;
        inClass  = cls;
        inRd     = rd;
        inRs1    = rs1;
        inRs2    = rs2;
        inFunct3 = f3;
        inFunct7 = f7;
        inImm    = imm;
        inLast   = last;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic [31:0] addr,
                              input logic [31:0] data);
        checkOutput({tag, ".we"}, {31'h0, memWe}, 32'h1);
        checkOutput({tag, ".addr"}, memAddr, addr);
        checkOutput({tag, ".wdata"}, memWdata, data);
    endtask

    task automatic pulseStart(input string tag);
        start = 1'b1;
        #1;
        checkOutput({tag, ".readyDuringStart"}, {31'h0, inReady}, 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        checkOutput({tag, ".count"}, {29'h0, count}, 32'h0);
        checkOutput({tag, ".done"}, {31'h0, done}, 32'h0);
        checkOutput({tag, ".error"}, {31'h0, error}, 32'h0);
        checkOutput({tag, ".ready"}, {31'h0, inReady}, 32'h1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".ready"}, {31'h0, inReady}, 32'h1);
        checkOutput({tag, ".we"}, {31'h0, memWe}, 32'h0);
        checkOutput({tag, ".addr"}, memAddr, BASE);
        checkOutput({tag, ".wdata"}, memWdata, 32'h0);
        checkOutput({tag, ".count"}, {29'h0, count}, 32'h0);
        checkOutput({tag, ".done"}, {31'h0, done}, 32'h0);
        checkOutput({tag, ".error"}, {31'h0, error}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        inClass = 3'd0; inRd = 5'd0; inRs1 = 5'd0; inRs2 = 5'd0;
        inFunct3 = 3'd0; inFunct7 = 7'd0; inImm = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;

        $display("[TB] load A: addi, add(last)");
        applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        checkWrite("addi", BASE + 32'h0, 32'h0050_0093);
        checkOutput("addi.count", {29'h0, count}, 32'd1);
        checkOutput("addi.done", {31'h0, done}, 32'h0);
        applyStimulus(CLS_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        checkWrite("add", BASE + 32'h4, 32'h0020_81B3);
        checkOutput("add.count", {29'h0, count}, 32'd2);
        checkOutput("add.done", {31'h0, done}, 32'h1);
        checkOutput("add.ready", {31'h0, inReady}, 32'h0);
        applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0);
        checkOutput("doneIgnore.we", {31'h0, memWe}, 32'h0);
        checkOutput("doneIgnore.addrHold", memAddr, BASE + 32'h4);
        checkOutput("doneIgnore.wdataHold", memWdata, 32'h0020_81B3);
        checkOutput("doneIgnore.count", {29'h0, count}, 32'd2);
        pulseStart("startA");

        $display("[TB] load B: sw, beq back-to-back");
        applyStimulus(CLS_S, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        checkWrite("sw", BASE + 32'h0, 32'h0020_A423);
        applyStimulus(CLS_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1);
        checkWrite("beq", BASE + 32'h4, 32'hFE00_0EE3);
        checkOutput("beq.done", {31'h0, done}, 32'h1);
        pulseStart("startB");

        $display("[TB] load C: fill DEPTH=4, stream 6");
        applyStimulus(CLS_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
        checkWrite("jal", BASE + 32'h0, 32'h0080_00EF);
        applyStimulus(CLS_U, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
        checkWrite("lui", BASE + 32'h4, 32'h1234_52B7);
        applyStimulus(CLS_LW, 5'd3, 5'd2, 5'd0, 3'd0, 7'd0, 32'd16, 1'b0);
        checkWrite("lw", BASE + 32'h8, 32'h0101_2183);
        checkOutput("lw.done", {31'h0, done}, 32'h0);
        applyStimulus(CLS_JALR, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0, 32'd4, 1'b0);
        checkWrite("jalr", BASE + 32'hC, 32'h0042_80E7);
        checkOutput("full.count", {29'h0, count}, 32'd4);
        checkOutput("full.done", {31'h0, done}, 32'h1);
        checkOutput("full.ready", {31'h0, inReady}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
            checkOutput("overflow.we", {31'h0, memWe}, 32'h0);
            checkOutput("overflow.count", {29'h0, count}, 32'd4);
        end
        pulseStart("startC");

        $display("[TB] load D: shift immediate and oversized addi");
        applyStimulus(CLS_I, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 1'b0);
        checkWrite("srai", BASE + 32'h0, 32'h4031_5093);
        applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
`ifdef ENCODER_IMM_CHECK_EN
        checkOutput("addiBig.we", {31'h0, memWe}, 32'h0);
        checkOutput("addiBig.count", {29'h0, count}, 32'd1);
        checkOutput("addiBig.error", {31'h0, error}, 32'h1);
        applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        checkWrite("addiAfterReject", BASE + 32'h4, 32'h0050_0093);
        checkOutput("addiAfterReject.error", {31'h0, error}, 32'h1);
`else
        checkWrite("addiBig", BASE + 32'h4, 32'h8000_0093);
        checkOutput("addiBig.count", {29'h0, count}, 32'd2);
        checkOutput("addiBig.error", {31'h0, error}, 32'h0);
        applyStimulus(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        checkWrite("addiAfterBig", BASE + 32'h8, 32'h0050_0093);
        checkOutput("addiAfterBig.error", {31'h0, error}, 32'h0);
`endif
        checkOutput("loadD.done", {31'h0, done}, 32'h1);
        pulseStart("startD");

`ifdef ENCODER_IMM_CHECK_EN
        $display("[TB] rejected last: odd branch offset");
        applyStimulus(CLS_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1);
        checkOutput("rejLast.we", {31'h0, memWe}, 32'h0);
        checkOutput("rejLast.done", {31'h0, done}, 32'h1);
        checkOutput("rejLast.error", {31'h0, error}, 32'h1);
        checkOutput("rejLast.count", {29'h0, count}, 32'd0);
        pulseStart("startRej");
`endif

        $display("[TB] start during LOAD");
        applyStimulus(CLS_I, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        checkWrite("preStart", BASE + 32'h0, 32'h0010_0113);
        pulseStart("startMid");
        applyStimulus(CLS_I, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        checkWrite("postStart", BASE + 32'h0, 32'h0020_0113);
        checkOutput("postStart.count", {29'h0, count}, 32'd1);

        $display("[TB] reset mid-load");
        applyStimulus(CLS_I, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        checkWrite("preRst", BASE + 32'h4, 32'h0030_0113);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset("rstAfterAccept");
        inValid = 1'b1;
        inClass = CLS_I; inRd = 5'd4; inRs1 = 5'd0; inFunct3 = 3'd0; inImm = 32'd9;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inValid = 1'b0;
        checkReset("rstDuringAccept");

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that turns instruction fields into 32-bit RV32I words and writes them sequentially into instruction memory. It emits exactly the eight opcodes `Main_controller` decodes: R, I, S, B, LUI, JAL, LW and JALR. It sits between the testbench or boot-loader front end and the instruction-memory write port. It accepts one instruction per cycle over a valid/ready handshake and reports completion and errors.

## Interface

Parameters:
- `DEPTH`, 256: maximum words written per load.
- `BASE_ADDR`, 32'h0: byte address of the first word.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; clears the counter and begins a new load.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: encoder can accept.
- `in_last` in 1: marks the final instruction of the load.
- `in_class` in 3: instruction class (R=0, I=1, S=2, B=3, U=4, J=5, LW=6, JALR=7).
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register fields.
- `in_funct3` in 3; `in_funct7` in 7.
- `in_imm` in 32: signed immediate, byte offset. For U, the full upper value.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: byte address, word-aligned.
- `mem_wdata` out 32: encoded word.
- `count` out `$clog2(DEPTH+1)`: words written so far.
- `done` out 1: load complete.
- `error` out 1: sticky; set when any instruction is rejected.

## Operation

**States.**
- `LOAD`: accepting instructions.
- `DONE`: load finished.

**Handshake.**
- `in_ready = (state==LOAD) && !start`.
- A transfer occurs when `in_valid && in_ready`.

**Encoding.** Opcodes are fixed per class: R 0110011, I 0010011, S 0100011, B 1100011, U 0110111, J 1101111, LW 0000011, JALR 1100111.
- LW forces funct3 = 010. JALR forces funct3 = 000.
- R, I, LW and JALR use rd. S and B place immediate bits in the rd slot. U and J use rd.
- Immediate bit scatter follows the standard S, B and J formats. B drops imm[0]. J drops imm[0].
- U takes imm[31:12].
- The I class uses `in_funct7` as imm[11:5] when funct3 is 001 or 101 (shifts).

**Writes.**
- An accepted, legal instruction produces `mem_we=1` on the next cycle.
- That write carries `mem_addr = BASE_ADDR + 4*count` and the encoded `mem_wdata`.
- `count` increments in the same cycle as the write.

**Rejection.** An accepted instruction that fails the immediate check (see Configuration) is rejected:
- it is consumed;
- no write is issued;
- `count` is unchanged;
- `error` is set and stays set until `start` or `rst`.

**LOAD → DONE.** Taken on the cycle after accepting an instruction with `in_last`. Also taken on the cycle after the write that makes `count == DEPTH`.

**DONE → LOAD.** Taken on `start`. Clears `count` and `error`.

**`start` during LOAD.**
- Clears `count` and `error`.
- Blocks acceptance that cycle.
- A write already in flight still completes. It lands at its already-computed address and does not increment the cleared count.

**Rejected last.** An `in_last` instruction that is rejected still ends the load.

## Timing

- Reset values:
  - state = `LOAD`;
  - `count` = 0;
  - `in_ready` = 1;
  - `mem_we` = 0;
  - `mem_addr` = `BASE_ADDR`;
  - `mem_wdata` = 0;
  - `done` = 0;
  - `error` = 0.
- Latency: acceptance in cycle N gives the write in cycle N+1. Throughput is one word per cycle.
- `done` is registered: high from the cycle after the final write or rejection until `start` or `rst`.
- `in_ready` falls in the same cycle `done` rises. Exactly `DEPTH` words can be written; a `DEPTH+1`th is never accepted.
- A `rst` asserted mid-load aborts any pending write on the next edge. `mem_we` is 0 the following cycle.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we=0`.

## Configuration

`ENCODER_IMM_CHECK_EN`:
- **Defined:** the immediate is range-checked, and a failing instruction is rejected and sets `error`.
  - I, LW, JALR, S: signed 12-bit.
  - B: signed 13-bit and even.
  - J: signed 21-bit and even.
  - U: imm[11:0] must be 0.
- **Undefined:** immediates are silently truncated or have their low bit dropped. `error` stays tied to 0.

## Structure

- Shared package `riscv_pkg` holds:
  - the opcode constants `R_T`, `I_T`, `S_T`, `B_T`, `U_T`, `J_T`, `LW`, `JALR` (also used by `Main_controller`);
  - the 3-bit `instr_class_t` encoding.
- Combinational sub-module `instr_format_enc`: maps class, fields and immediate to a 32-bit word plus an `imm_ok` flag.
- The top level holds the FSM, the counter, the output register and the sticky error.

## Test plan

- addi x1,x0,5 (I, imm 5, rd 1), then R add x3,x1,x2 with `in_last`: words 0x00500093 at 0x0 and 0x002081B3 at 0x4; then `done`=1 and `count`=2.
- sw x2,8(x1) → 0x0020A423. beq x0,x0,-4 → 0xFE000EE3. Both written back-to-back with `in_valid` held high.
- jal x1,8 → 0x008000EF. lui x5,0x12345000 → 0x123452B7. LW forces funct3 010; JALR forces funct3 000.
- With `ENCODER_IMM_CHECK_EN`, addi imm 2048: no write, `count` unchanged, `error`=1. The next legal word is written at the unchanged address. Without the macro, 0x80000093 is written and `error`=0.
- `DEPTH`=4 with 6 instructions streamed: 4 writes, then `in_ready`=0 and `done`=1. A `start` pulse restarts with `count`=0 and the next write at `BASE_ADDR`.
- `rst` asserted in the cycle after an accept: no `mem_we` in the following cycle, and all outputs at their reset values.
